// File: rtl/bitflip_scrubber.sv
// Checkerboard memory scrubber: fills a test memory once, then loops reading
// each word, reporting per-bit flips on flip_o and rewriting corrupted words.
module bitflip_scrubber #(
   parameter int IN_DATA_WIDTH = 100,
   parameter int NUM_WORDS     = 64,
   parameter int ADDR_WIDTH    = $clog2(NUM_WORDS),
   parameter int SCAN_GAP      = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [ADDR_WIDTH-1:0]    mem_addr_o,
   output logic [IN_DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                     mem_gnt_i,
   input  logic                     mem_rvalid_i,
   input  logic [IN_DATA_WIDTH-1:0] mem_rdata_i,
   output logic [IN_DATA_WIDTH-1:0] flip_o,
   output logic                     scan_done_o,
   output logic [15:0]              scan_cnt_o,
   output logic                     busy_o
);

   typedef enum logic [2:0] {IDLE, FILL, GAP, RD, WAIT, REPAIR} state_t;

   localparam int GAP_WIDTH = (SCAN_GAP > 0) ? $clog2(SCAN_GAP + 1) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
   localparam logic [GAP_WIDTH-1:0]  GAP_LOAD  = GAP_WIDTH'(SCAN_GAP);

   state_t                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [GAP_WIDTH-1:0]     gap_q, gap_d;
   logic [IN_DATA_WIDTH-1:0] flip_q, flip_d;
   logic                     done_q, done_d;
   logic [15:0]              cnt_q, cnt_d;
   logic [IN_DATA_WIDTH-1:0] pattern;
   logic [IN_DATA_WIDTH-1:0] diff;
   logic                     advance;

   // Checkerboard: even addresses set the even bits, odd addresses the odd bits.
   always_comb begin
      pattern = '0;
      for (int i = 0; i < IN_DATA_WIDTH; i++) begin
         pattern[i] = ~(1'(i) ^ addr_q[0]);
      end
   end

   assign diff = mem_rdata_i ^ pattern;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      gap_d   = gap_q;
      flip_d  = '0;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_i) begin
               state_d = FILL;
               addr_d  = '0;
            end
         end
         FILL: begin
            if (mem_gnt_i) begin
               if (addr_q == LAST_ADDR) begin
                  addr_d  = '0;
                  gap_d   = GAP_LOAD;
                  state_d = GAP;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         GAP: begin
            gap_d = (gap_q == '0) ? '0 : gap_q - 1'b1;
            if (!enable_i) begin
               state_d = IDLE;
            end else if (gap_q == '0) begin
               state_d = RD;
            end
         end
         RD: begin
            if (mem_gnt_i) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rvalid_i) begin
               flip_d = diff;
               if (diff != '0) state_d = REPAIR;
               else            advance = 1'b1;
            end
         end
         REPAIR: begin
            if (mem_gnt_i) advance = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Word boundary: the only place enable_i can stop a running scan.
      if (advance) begin
         if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            done_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            if (enable_i) begin
               state_d = GAP;
               gap_d   = GAP_LOAD;
            end else begin
               state_d = IDLE;
            end
         end else begin
            addr_d  = addr_q + 1'b1;
            state_d = enable_i ? RD : IDLE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         gap_q   <= '0;
         flip_q  <= '0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         gap_q   <= gap_d;
         flip_q  <= flip_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_req_o   = (state_q == FILL) || (state_q == RD) || (state_q == REPAIR);
   assign mem_we_o    = (state_q == FILL) || (state_q == REPAIR);
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = mem_we_o ? pattern : '0;
   assign flip_o      = flip_q;
   assign scan_done_o = done_q;
   assign scan_cnt_o  = cnt_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_bitflip_scrubber.sv
// Self-checking bench for bitflip_scrubber: a memory model with 2-cycle read
// latency, injectable corruption and grant stalls, plus directed scan checks.
module tb_bitflip_scrubber;

   localparam int W = 100;
   localparam logic [W-1:0] PAT_EVEN = 100'h5555555555555555555555555;
   localparam logic [W-1:0] PAT_ODD  = 100'hAAAAAAAAAAAAAAAAAAAAAAAAA;

   typedef struct {
      int           addr;
      logic [W-1:0] data;
      int           cyc;
   } txn_t;

   typedef struct {
      int           addr;
      logic [W-1:0] mask;
      logic [W-1:0] exp_flip;
      int           exp_repairs;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         enable_i;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [5:0]   mem_addr_o;
   logic [W-1:0] mem_wdata_o;
   logic         mem_gnt_i;
   logic         mem_rvalid_i;
   logic [W-1:0] mem_rdata_i;
   logic [W-1:0] flip_o;
   logic         scan_done_o;
   logic [15:0]  scan_cnt_o;
   logic         busy_o;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] mem [64];
   int           cyc = 0;
   int           nflip = 0;
   int           ndone = 0;
   int           nreq = 0;
   int           flip_cyc = 0;
   int           done_cyc = 0;
   int           flip_addr = -1;
   logic [W-1:0] flip_val = '0;
   int           last_rv_addr = -1;
   int           rd_cnt = 0;
   int           rd_addr = 0;
   int           stall_left = 0;
   bit           stall_active = 1'b0;
   int           stall_bad = 0;
   logic [5:0]   st_addr = '0;
   logic [W-1:0] st_data = '0;
   txn_t         wq[$];
   txn_t         rq[$];
   int           cor_done = 0;
   int           stl_done = 0;
   int           stray_done = 0;
   int           drop_done = 0;

   int           cor_seq = 0;
   int           cor_addr = 0;
   logic [W-1:0] cor_mask = '0;
   int           stl_seq = 0;
   int           stl_amt = 0;
   int           stray_seq = 0;
   int           drop_seq = 0;

   always #5 clk = ~clk;

   bitflip_scrubber #(
      .IN_DATA_WIDTH(W),
      .NUM_WORDS    (64),
      .SCAN_GAP     (16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .enable_i    (enable_i),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_gnt_i   (mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i (mem_rdata_i),
      .flip_o      (flip_o),
      .scan_done_o (scan_done_o),
      .scan_cnt_o  (scan_cnt_o),
      .busy_o      (busy_o)
   );

   function automatic logic [W-1:0] pat(input int a);
      return (a % 2 == 0) ? PAT_EVEN : PAT_ODD;
   endfunction

   task automatic applyStimulus(input logic r, input logic e);
      rst_i    = r;
      enable_i = e;
   endtask

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_done(input int target, input string name);
      for (int n = 0; n < 3000 && ndone < target; n++) @(negedge clk);
      checkOutput(name, 256'(ndone >= target), 256'(1));
   endtask

   // Memory model and output monitor; acts at the falling edge so every
   // response is settled before the DUT samples it.
   initial begin
      for (int a = 0; a < 64; a++) mem[a] = '0;
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (flip_o !== '0 && flip_o !== 'x) begin
            nflip++;
            flip_val  = flip_o;
            flip_addr = last_rv_addr;
            flip_cyc  = cyc;
         end
         if (scan_done_o === 1'b1) begin
            ndone++;
            done_cyc = cyc;
         end
         if (mem_req_o === 1'b1) nreq++;
         if (cor_seq != cor_done) begin
            mem[cor_addr] = mem[cor_addr] ^ cor_mask;
            cor_done      = cor_seq;
         end
         if (stl_seq != stl_done) begin
            stall_left   = stl_amt;
            stall_active = 1'b0;
            stl_done     = stl_seq;
         end
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = '0;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = mem[rd_addr];
               last_rv_addr = rd_addr;
            end
         end
         if (stray_seq != stray_done) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = {W{1'b1}};
            stray_done   = stray_seq;
         end
         if (stall_active && !(mem_req_o === 1'b1 && mem_we_o === 1'b1 &&
                               mem_addr_o == st_addr && mem_wdata_o == st_data))
            stall_bad++;
         if (mem_req_o === 1'b1 && mem_we_o === 1'b1 && stall_left > 0) begin
            if (!stall_active) begin
               st_addr      = mem_addr_o;
               st_data      = mem_wdata_o;
               stall_active = 1'b1;
            end
            stall_left--;
            mem_gnt_i = 1'b0;
         end else begin
            mem_gnt_i    = 1'b1;
            stall_active = 1'b0;
         end
         if (mem_req_o === 1'b1 && mem_gnt_i) begin
            if (mem_we_o) begin
               mem[mem_addr_o] = mem_wdata_o;
               wq.push_back('{int'(mem_addr_o), mem_wdata_o, cyc});
            end else begin
               rq.push_back('{int'(mem_addr_o), '0, cyc});
               rd_addr = int'(mem_addr_o);
               rd_cnt  = 2;
               if (drop_seq != drop_done && mem_addr_o == 6'd10) drop_done = drop_seq;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t vecs[5];
      int   nflip0, nwr0, ndone0, nreq0;
      bit   ok;

      vecs[0] = '{5,  100'd1 << 3,                      100'd1 << 3,                      1};
      vecs[1] = '{5,  '0,                               '0,                               0};
      vecs[2] = '{0,  {W{1'b1}},                        {W{1'b1}},                        1};
      vecs[3] = '{62, (100'd1 << 98) | (100'd1 << 1),   (100'd1 << 98) | (100'd1 << 1),   1};
      vecs[4] = '{33, 100'd1 << 99,                     100'd1 << 99,                     1};

      // Reset, then fill with grant tied high
      applyStimulus(1'b1, 1'b0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("reset_outputs",
            {30'd0, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, flip_o, scan_done_o, scan_cnt_o, busy_o},
            '0);
      end
      applyStimulus(1'b0, 1'b1);
      for (int n = 0; n < 300 && wq.size() < 64; n++) @(negedge clk);
      checkOutput("fill_count", 256'(wq.size()), 256'(64));
      if (wq.size() >= 64) begin
         ok = 1'b1;
         for (int k = 0; k < 64; k++) ok &= (wq[k].addr == k) && (wq[k].data == pat(k));
         checkOutput("fill_sequence", 256'(ok), 256'(1));
         checkOutput("fill_word0", 256'(wq[0].data), 256'(PAT_EVEN));
         checkOutput("fill_word1", 256'(wq[1].data), 256'(PAT_ODD));
         checkOutput("fill_consecutive", 256'(wq[63].cyc - wq[0].cyc), 256'(63));
      end

      // Clean first scan
      wait_done(1, "scan1_done");
      checkOutput("scan1_no_flip", 256'(nflip), 256'(0));
      checkOutput("scan1_cnt", 256'(scan_cnt_o), 256'(1));
      checkOutput("scan1_writes", 256'(wq.size()), 256'(64));
      checkOutput("scan1_reads", 256'(rq.size()), 256'(64));
      if (rq.size() >= 64 && wq.size() >= 64) begin
         ok = 1'b1;
         for (int k = 0; k < 64; k++) ok &= (rq[k].addr == k);
         checkOutput("scan1_read_order", 256'(ok), 256'(1));
         checkOutput("gap_after_fill", 256'(rq[0].cyc - wq[63].cyc), 256'(18));
         checkOutput("scan1_done_timing", 256'(done_cyc - rq[63].cyc), 256'(3));
      end

      // Table of single-word corruptions, one scan each
      for (int k = 0; k < 5; k++) begin
         nflip0   = nflip;
         nwr0     = wq.size();
         ndone0   = ndone;
         cor_addr = vecs[k].addr;
         cor_mask = vecs[k].mask;
         cor_seq++;
         wait_done(ndone0 + 1, $sformatf("vec%0d_done", k));
         checkOutput($sformatf("vec%0d_flip_pulses", k), 256'(nflip - nflip0), 256'(vecs[k].exp_repairs));
         checkOutput($sformatf("vec%0d_repairs", k), 256'(wq.size() - nwr0), 256'(vecs[k].exp_repairs));
         checkOutput($sformatf("vec%0d_mem_clean", k), 256'(mem[vecs[k].addr]), 256'(pat(vecs[k].addr)));
         checkOutput($sformatf("vec%0d_scan_cnt", k), 256'(scan_cnt_o), 256'(k + 2));
         if (vecs[k].exp_repairs != 0 && wq.size() > nwr0) begin
            checkOutput($sformatf("vec%0d_flip_value", k), 256'(flip_val), 256'(vecs[k].exp_flip));
            checkOutput($sformatf("vec%0d_flip_addr", k), 256'(flip_addr), 256'(vecs[k].addr));
            checkOutput($sformatf("vec%0d_repair_addr", k), 256'(wq[nwr0].addr), 256'(vecs[k].addr));
            checkOutput($sformatf("vec%0d_repair_data", k), 256'(wq[nwr0].data), 256'(pat(vecs[k].addr)));
         end
      end
      if (rq.size() > 64)
         checkOutput("gap_after_scan", 256'(rq[64].cyc - rq[63].cyc), 256'(20));

      // Two-bit flip on the last word with a 5-cycle grant stall on the repair
      nwr0     = wq.size();
      ndone0   = ndone;
      cor_addr = 63;
      cor_mask = (100'd1 << 99) | 100'd1;
      cor_seq++;
      stl_amt  = 5;
      stl_seq++;
      wait_done(ndone0 + 1, "stall_done");
      checkOutput("stall_flip_value", 256'(flip_val), 256'((100'd1 << 99) | 100'd1));
      checkOutput("stall_flip_addr", 256'(flip_addr), 256'(63));
      checkOutput("stall_stable", 256'(stall_bad), 256'(0));
      checkOutput("stall_repairs", 256'(wq.size() - nwr0), 256'(1));
      if (wq.size() > nwr0) begin
         checkOutput("stall_length", 256'(wq[nwr0].cyc - flip_cyc), 256'(5));
         checkOutput("stall_done_timing", 256'(done_cyc - wq[nwr0].cyc), 256'(1));
      end
      checkOutput("stall_scan_cnt", 256'(scan_cnt_o), 256'(7));

      // Drop enable between the read grant and rvalid of address 10
      nwr0     = wq.size();
      cor_addr = 10;
      cor_mask = 100'd1 << 7;
      cor_seq++;
      drop_seq++;
      for (int n = 0; n < 1000 && drop_done != drop_seq; n++) @(negedge clk);
      checkOutput("drop_read_seen", 256'(drop_done == drop_seq), 256'(1));
      applyStimulus(1'b0, 1'b0);
      for (int n = 0; n < 100 && busy_o !== 1'b0; n++) @(negedge clk);
      nreq0 = nreq;
      repeat (20) @(negedge clk);
      checkOutput("drop_busy", 256'(busy_o), 256'(0));
      checkOutput("drop_no_requests", 256'(nreq - nreq0), 256'(0));
      checkOutput("drop_flip_value", 256'(flip_val), 256'(100'd1 << 7));
      checkOutput("drop_flip_addr", 256'(flip_addr), 256'(10));
      checkOutput("drop_last_read", 256'(rq[rq.size()-1].addr), 256'(10));
      checkOutput("drop_repairs", 256'(wq.size() - nwr0), 256'(1));
      checkOutput("drop_scan_cnt", 256'(scan_cnt_o), 256'(7));

      // Re-enable restarts with a full fill and keeps the scan count
      nwr0 = wq.size();
      applyStimulus(1'b0, 1'b1);
      for (int n = 0; n < 300 && wq.size() < nwr0 + 64; n++) @(negedge clk);
      checkOutput("refill_count", 256'(wq.size() - nwr0), 256'(64));
      if (wq.size() >= nwr0 + 64) begin
         checkOutput("refill_first_addr", 256'(wq[nwr0].addr), 256'(0));
         checkOutput("refill_first_data", 256'(wq[nwr0].data), 256'(PAT_EVEN));
         checkOutput("refill_last_addr", 256'(wq[nwr0+63].addr), 256'(63));
      end
      checkOutput("refill_scan_cnt", 256'(scan_cnt_o), 256'(7));

      // Reset while a repair write is held off by the grant
      cor_addr = 2;
      cor_mask = 100'h3;
      cor_seq++;
      stl_amt  = 100;
      stl_seq++;
      for (int n = 0; n < 1000 && !stall_active; n++) @(negedge clk);
      checkOutput("rst_repair_reached", 256'(stall_active), 256'(1));
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      checkOutput("rst_repair_req", 256'(mem_req_o), 256'(0));
      checkOutput("rst_repair_busy", 256'(busy_o), 256'(0));
      checkOutput("rst_repair_cnt", 256'(scan_cnt_o), 256'(0));
      checkOutput("rst_repair_addr", 256'(mem_addr_o), 256'(0));
      stl_amt = 0;
      stl_seq++;
      applyStimulus(1'b0, 1'b0);
      nflip0 = nflip;
      stray_seq++;
      repeat (4) @(negedge clk);
      checkOutput("stray_rvalid_no_flip", 256'(nflip - nflip0), 256'(0));
      checkOutput("stray_flip_out", 256'(flip_o), 256'(0));
      checkOutput("stray_busy", 256'(busy_o), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
